// File: rtl/usb_defs.sv
// usb_defs: shared USB token, handshake and data PID encodings plus transactor state codes.
package usb_defs;
    localparam logic [1:0] TOK_OUT   = 2'b00;
    localparam logic [1:0] TOK_SOF   = 2'b01;
    localparam logic [1:0] TOK_IN    = 2'b10;
    localparam logic [1:0] TOK_SETUP = 2'b11;
    localparam logic [1:0] HSK_ACK   = 2'b00;
    localparam logic [1:0] HSK_NAK   = 2'b10;
    localparam logic [1:0] HSK_STALL = 2'b11;
    localparam logic [1:0] DATA0     = 2'b00;
    localparam logic [1:0] DATA1     = 2'b10;
    typedef enum logic [2:0] {
        IDLE, CTRL, OUT_DAT, OUT_HSK, IN_DAT, IN_WAIT, HSK, DUMP
    } state_t;
endpackage

// File: rtl/ep_toggle.sv
// ep_toggle: per-endpoint DATA0/DATA1 toggle bits; a clear beats a same-cycle flip.
module ep_toggle #(
    parameter int NUM_EPS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_EPS-1:0] flip,
    input  logic [NUM_EPS-1:0] clear,
    output logic [NUM_EPS-1:0] tog
);
    always_ff @(posedge clock) begin
        if (reset) tog <= '0;
        else tog <= (tog ^ flip) & ~clear;
    end
endmodule

// File: rtl/ep_transactor.sv
// ep_transactor: USB device transaction engine; hands SETUP to the control unit and
// runs bulk IN/OUT data phases with handshakes and per-endpoint data toggles.
module ep_transactor
    import usb_defs::*;
#(
    parameter int NUM_EPS = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [6:0]         usb_addr_i,
    input  logic               tok_recv_i,
    input  logic [1:0]         tok_type_i,
    input  logic [6:0]         tok_addr_i,
    input  logic [3:0]         tok_endp_i,
    input  logic               usb_recv_i,
    input  logic [1:0]         usb_type_i,
    input  logic               usb_err_i,
    input  logic               hsk_recv_i,
    input  logic [1:0]         hsk_type_i,
    output logic               hsk_send_o,
    output logic [1:0]         hsk_type_o,
    input  logic               hsk_sent_i,
    output logic               usb_send_o,
    output logic [1:0]         usb_type_o,
    input  logic               usb_sent_i,
    output logic               ctl_start_o,
    input  logic               ctl_done_i,
    input  logic               ctl_error_i,
    output logic [2:0]         ep_sel_o,
    input  logic [NUM_EPS-1:0] blk_rdy_i,
    input  logic [NUM_EPS-1:0] blk_avail_i,
    input  logic [NUM_EPS-1:0] stall_i,
    input  logic [NUM_EPS-1:0] clr_tog_i,
    output logic               blk_start_o,
    output logic               blk_commit_o,
    output logic               blk_drop_o,
    output logic               fsm_idle_o,
    output logic               fsm_bulk_o,
    output logic               fsm_ctrl_o,
    output logic               fsm_dump_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_n;
    logic [2:0] ep, ep_n;
    logic [1:0] hsk_type, hsk_type_n;
    logic [CW-1:0] cnt;
    logic [NUM_EPS-1:0] tog, flip, ep_mask, tok_mask;
    logic ctl_start_n, blk_start_n, blk_commit_n, blk_drop_n, do_flip;
    logic tok_me, timeout, cur_tog, pid_bad, rdy;
    // Endpoint n maps to bit n-1; endpoint 0 shifts out to an all-zero mask.
    assign ep_mask  = NUM_EPS'(1) << (ep - 3'd1);
    assign tok_mask = NUM_EPS'(1) << (tok_endp_i - 4'd1);
    assign tok_me   = tok_recv_i && tok_addr_i == usb_addr_i;
    assign timeout  = cnt == CW'(TIMEOUT);
    assign cur_tog  = |(tog & ep_mask);
    assign pid_bad  = usb_type_i != (cur_tog ? DATA1 : DATA0);
    assign rdy      = |(blk_rdy_i & ep_mask);
    assign flip     = do_flip ? ep_mask : '0;
    ep_toggle #(.NUM_EPS(NUM_EPS)) u_tog (
        .clock(clock),
        .reset(reset),
        .flip(flip),
        .clear(clr_tog_i),
        .tog(tog)
    );
    always_comb begin
        state_n = state;
        ep_n = ep;
        hsk_type_n = hsk_type;
        ctl_start_n = 1'b0;
        blk_start_n = 1'b0;
        blk_commit_n = 1'b0;
        blk_drop_n = 1'b0;
        do_flip = 1'b0;
        case (state)
            IDLE: if (tok_me && tok_type_i != TOK_SOF) begin
                if (tok_type_i == TOK_SETUP) begin
                    state_n = tok_endp_i == 4'd0 ? CTRL : DUMP;
                    ctl_start_n = tok_endp_i == 4'd0;
                end else if (tok_endp_i == 4'd0 || tok_endp_i > 4'(NUM_EPS)) begin
                    state_n = DUMP;
                end else begin
                    ep_n = 3'(tok_endp_i);
                    if (|(stall_i & tok_mask)) begin
                        state_n = HSK;
                        hsk_type_n = HSK_STALL;
                    end else if (tok_type_i == TOK_OUT) begin
                        state_n = OUT_DAT;
                        blk_start_n = 1'b1;
                    end else if (|(blk_avail_i & tok_mask)) begin
                        state_n = IN_DAT;
                        blk_start_n = 1'b1;
                    end else begin
                        state_n = HSK;
                        hsk_type_n = HSK_NAK;
                    end
                end
            end
            CTRL: state_n = ctl_error_i ? DUMP : ctl_done_i ? IDLE : CTRL;
            OUT_DAT: if (tok_recv_i) begin
                state_n = IDLE;
            end else if (usb_recv_i) begin
                blk_drop_n = usb_err_i || pid_bad || !rdy;
                blk_commit_n = !blk_drop_n;
                do_flip = blk_commit_n;
                state_n = usb_err_i ? IDLE : OUT_HSK;
                hsk_type_n = (!pid_bad && !rdy) ? HSK_NAK : HSK_ACK;
            end
            OUT_HSK, HSK: state_n = (tok_recv_i || hsk_sent_i) ? IDLE : state;
            IN_DAT: state_n = tok_recv_i ? IDLE : usb_sent_i ? IN_WAIT : IN_DAT;
            IN_WAIT: if (tok_recv_i || timeout) begin
                state_n = IDLE;
            end else if (hsk_recv_i) begin
                do_flip = hsk_type_i == HSK_ACK;
                state_n = IDLE;
            end
            DUMP: state_n = (tok_me || timeout) ? IDLE : DUMP;
        endcase
        if (state_n == IDLE) ep_n = 3'd0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ep <= 3'd0;
            hsk_type <= HSK_ACK;
            cnt <= '0;
            ctl_start_o <= 1'b0;
            blk_start_o <= 1'b0;
            blk_commit_o <= 1'b0;
            blk_drop_o <= 1'b0;
        end else begin
            state <= state_n;
            ep <= ep_n;
            hsk_type <= hsk_type_n;
            cnt <= state_n != state ? '0 : timeout ? cnt : cnt + 1'b1;
            ctl_start_o <= ctl_start_n;
            blk_start_o <= blk_start_n;
            blk_commit_o <= blk_commit_n;
            blk_drop_o <= blk_drop_n;
        end
    end
    assign hsk_send_o = state == HSK || state == OUT_HSK;
    assign hsk_type_o = hsk_type;
    assign usb_send_o = state == IN_DAT;
    assign usb_type_o = (usb_send_o && cur_tog) ? DATA1 : DATA0;
    assign ep_sel_o   = ep;
    assign fsm_idle_o = state == IDLE;
    assign fsm_ctrl_o = state == CTRL;
    assign fsm_dump_o = state == DUMP;
    assign fsm_bulk_o = !(fsm_idle_o || fsm_ctrl_o || fsm_dump_o);
endmodule

// File: tb/tb_ep_transactor.sv
// tb_ep_transactor: directed vectors for the bulk/control transaction engine.
module tb_ep_transactor;
    localparam int NE = 2;
    localparam int TO = 20;
    localparam logic [1:0] T_OUT = 2'b00, T_SOF = 2'b01, T_IN = 2'b10, T_SETUP = 2'b11;
    localparam logic [1:0] ACK = 2'b00, NAK = 2'b10, STALL = 2'b11;
    localparam logic [1:0] D0 = 2'b00, D1 = 2'b10;
    logic clock = 1'b0, reset = 1'b1;
    logic [6:0] usb_addr_i = 7'd3, tok_addr_i = '0;
    logic tok_recv_i = 0, usb_recv_i = 0, usb_err_i = 0, hsk_recv_i = 0;
    logic [1:0] tok_type_i = '0, usb_type_i = '0, hsk_type_i = '0;
    logic [3:0] tok_endp_i = '0;
    logic hsk_sent_i = 0, usb_sent_i = 0, ctl_done_i = 0, ctl_error_i = 0;
    logic [NE-1:0] blk_rdy_i = '0, blk_avail_i = '0, stall_i = '0, clr_tog_i = '0;
    logic hsk_send_o, usb_send_o, ctl_start_o, blk_start_o, blk_commit_o, blk_drop_o;
    logic [1:0] hsk_type_o, usb_type_o;
    logic [2:0] ep_sel_o;
    logic fsm_idle_o, fsm_bulk_o, fsm_ctrl_o, fsm_dump_o;
    int total = 0, bad = 0;
    always #5 clock = ~clock;
    ep_transactor #(.NUM_EPS(NE), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .usb_addr_i(usb_addr_i),
        .tok_recv_i(tok_recv_i), .tok_type_i(tok_type_i), .tok_addr_i(tok_addr_i), .tok_endp_i(tok_endp_i),
        .usb_recv_i(usb_recv_i), .usb_type_i(usb_type_i), .usb_err_i(usb_err_i),
        .hsk_recv_i(hsk_recv_i), .hsk_type_i(hsk_type_i),
        .hsk_send_o(hsk_send_o), .hsk_type_o(hsk_type_o), .hsk_sent_i(hsk_sent_i),
        .usb_send_o(usb_send_o), .usb_type_o(usb_type_o), .usb_sent_i(usb_sent_i),
        .ctl_start_o(ctl_start_o), .ctl_done_i(ctl_done_i), .ctl_error_i(ctl_error_i),
        .ep_sel_o(ep_sel_o), .blk_rdy_i(blk_rdy_i), .blk_avail_i(blk_avail_i),
        .stall_i(stall_i), .clr_tog_i(clr_tog_i),
        .blk_start_o(blk_start_o), .blk_commit_o(blk_commit_o), .blk_drop_o(blk_drop_o),
        .fsm_idle_o(fsm_idle_o), .fsm_bulk_o(fsm_bulk_o), .fsm_ctrl_o(fsm_ctrl_o), .fsm_dump_o(fsm_dump_o)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clock);
    endtask
    task automatic token(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e);
        tok_type_i = t; tok_addr_i = a; tok_endp_i = e; tok_recv_i = 1;
        tick();
        tok_recv_i = 0;
    endtask
    task automatic send_data(input logic [1:0] pid, input logic err);
        usb_type_i = pid; usb_err_i = err; usb_recv_i = 1;
        tick();
        usb_recv_i = 0; usb_err_i = 0;
    endtask
    task automatic hsk_in(input logic [1:0] t);
        hsk_type_i = t; hsk_recv_i = 1;
        tick();
        hsk_recv_i = 0;
    endtask
    task automatic hsk_done();
        hsk_sent_i = 1;
        tick();
        hsk_sent_i = 0;
    endtask
    task automatic usb_done();
        usb_sent_i = 1;
        tick();
        usb_sent_i = 0;
    endtask
    task automatic wait_idle(input string tag, input int lo, input int hi);
        int n = 0;
        while (!fsm_idle_o && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n >= lo && n <= hi), 1);
    endtask
    initial begin
        repeat (3) tick();
        check("rst_idle", fsm_idle_o, 1);
        check("rst_outs", {hsk_send_o, usb_send_o, ctl_start_o, blk_start_o, blk_commit_o, blk_drop_o}, 0);
        check("rst_types", {ep_sel_o, hsk_type_o, usb_type_o}, 0);
        reset = 0;
        tick();
        check("idle_after_rst", {fsm_idle_o, fsm_bulk_o, fsm_ctrl_o, fsm_dump_o}, 4'b1000);
        // OUT EP1 DATA0 accepted
        blk_rdy_i = 2'b11; blk_avail_i = 2'b11;
        token(T_OUT, 3, 1);
        check("out_start", {blk_start_o, fsm_bulk_o, ep_sel_o}, {2'b11, 3'd1});
        send_data(D0, 0);
        check("out_commit", {blk_commit_o, blk_drop_o}, 2'b10);
        check("out_ack", {hsk_send_o, hsk_type_o}, {1'b1, ACK});
        tick();
        check("out_ack_held", {hsk_send_o, hsk_type_o}, {1'b1, ACK});
        hsk_done();
        check("out_done_idle", {fsm_idle_o, ep_sel_o}, 4'b1000);
        token(T_IN, 3, 1);
        check("ep1_tog_d1", {usb_send_o, usb_type_o}, {1'b1, D1});
        usb_done();
        check("in_wait", {usb_send_o, fsm_bulk_o}, 2'b01);
        hsk_in(NAK);
        check("in_nak_idle", fsm_idle_o, 1);
        // duplicate DATA0: drop and ACK, toggle stays DATA1
        token(T_OUT, 3, 1);
        send_data(D0, 0);
        check("dup_drop", {blk_commit_o, blk_drop_o, hsk_send_o, hsk_type_o}, {3'b011, ACK});
        hsk_done();
        token(T_OUT, 3, 1);
        send_data(D1, 0);
        check("d1_commit", {blk_commit_o, blk_drop_o, hsk_type_o}, {2'b10, ACK});
        hsk_done();
        blk_rdy_i = 2'b00;
        token(T_OUT, 3, 1);
        send_data(D0, 0);
        check("out_nak", {blk_commit_o, blk_drop_o, hsk_send_o, hsk_type_o}, {3'b011, NAK});
        hsk_done();
        blk_rdy_i = 2'b11;
        token(T_OUT, 3, 1);
        send_data(D0, 1);
        check("out_err", {blk_drop_o, hsk_send_o, fsm_idle_o}, 3'b101);
        // IN EP2: NAK, timeout, retry, ACK
        blk_avail_i = 2'b01;
        token(T_IN, 3, 2);
        check("in_nak", {hsk_send_o, hsk_type_o, ep_sel_o, fsm_bulk_o}, {1'b1, NAK, 3'd2, 1'b1});
        hsk_done();
        blk_avail_i = 2'b11;
        token(T_IN, 3, 2);
        check("in2_d0", {usb_send_o, usb_type_o, ep_sel_o}, {1'b1, D0, 3'd2});
        tick();
        check("in2_held", usb_send_o, 1);
        usb_done();
        wait_idle("in_timeout", TO, TO + 1);
        token(T_IN, 3, 2);
        check("retry_d0", {usb_send_o, usb_type_o}, {1'b1, D0});
        usb_done();
        hsk_in(ACK);
        check("in_ack_idle", fsm_idle_o, 1);
        token(T_IN, 3, 2);
        check("ep2_tog_d1", {usb_send_o, usb_type_o}, {1'b1, D1});
        token(T_SOF, 0, 0);
        check("abort_idle", {fsm_idle_o, usb_send_o}, 2'b10);
        // stall, foreign address, bad endpoint
        stall_i = 2'b01;
        token(T_IN, 3, 1);
        check("stall", {hsk_send_o, hsk_type_o, ep_sel_o}, {1'b1, STALL, 3'd1});
        hsk_done();
        stall_i = 2'b00;
        token(T_OUT, 5, 1);
        check("other_addr", {fsm_idle_o, blk_start_o}, 2'b10);
        repeat (3) tick();
        check("other_quiet", {fsm_idle_o, hsk_send_o, usb_send_o}, 3'b100);
        token(T_OUT, 3, 3);
        check("bad_ep_dump", {fsm_dump_o, blk_start_o, hsk_send_o}, 3'b100);
        token(T_SOF, 3, 0);
        check("dump_exit", fsm_idle_o, 1);
        // control transfers
        token(T_SETUP, 3, 0);
        check("setup_start", {ctl_start_o, fsm_ctrl_o, ep_sel_o}, {2'b11, 3'd0});
        tick();
        check("setup_pulse", {ctl_start_o, fsm_ctrl_o}, 2'b01);
        ctl_error_i = 1; ctl_done_i = 1;
        tick();
        ctl_error_i = 0; ctl_done_i = 0;
        check("ctl_err_wins", fsm_dump_o, 1);
        wait_idle("dump_timeout", TO, TO + 1);
        token(T_SETUP, 3, 0);
        ctl_done_i = 1;
        tick();
        ctl_done_i = 0;
        check("ctl_done", fsm_idle_o, 1);
        token(T_SETUP, 3, 1);
        check("setup_ep1_dump", {fsm_dump_o, ctl_start_o}, 2'b10);
        token(T_OUT, 3, 0);
        check("dump_tok_exit", fsm_idle_o, 1);
        // clear beats a same-cycle ACK flip on EP1 (toggle currently DATA0)
        token(T_IN, 3, 1);
        check("ep1_d0", usb_type_o, D0);
        usb_done();
        clr_tog_i = 2'b01;
        hsk_in(ACK);
        clr_tog_i = 2'b00;
        token(T_IN, 3, 1);
        check("clr_override", {usb_send_o, usb_type_o}, {1'b1, D0});
        token(T_SOF, 0, 0);
        // reset during IN_DAT on EP2 (toggle DATA1)
        token(T_IN, 3, 2);
        check("pre_rst_d1", {usb_send_o, usb_type_o}, {1'b1, D1});
        reset = 1;
        tick();
        check("rst_mid", {usb_send_o, fsm_idle_o, hsk_send_o}, 3'b010);
        reset = 0;
        repeat (2) tick();
        check("rst_quiet", {usb_send_o, hsk_send_o}, 2'b00);
        token(T_IN, 3, 2);
        check("rst_tog_d0", {usb_send_o, usb_type_o}, {1'b1, D0});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
